// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM states and the ALU function-select codes.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Function codes decoded by the ALU top result mux.
  localparam logic [1:0] FUNC_ADD = 2'b00;
  localparam logic [1:0] FUNC_SUB = 2'b01;
  localparam logic [1:0] FUNC_MUL = 2'b10;
  localparam logic [1:0] FUNC_DIV = 2'b11;

endpackage

// File: rtl/div_step.sv
// One restoring-division step (combinational).
//   rem        : current partial remainder (always < divisor)
//   dvd_bit    : next dividend bit shifted into the remainder
//   divisor    : divisor
//   rem_next_c : partial remainder after this step
//   q_bit_c    : quotient bit produced by this step
module div_step #(
  parameter int unsigned width = 6
) (
  input  logic [width-1:0] rem,
  input  logic             dvd_bit,
  input  logic [width-1:0] divisor,
  output logic [width-1:0] rem_next_c,
  output logic             q_bit_c
);

  localparam int unsigned PW = width + 1;

  logic [PW-1:0] shifted;
  logic [PW:0]   trial;

  // Trial subtract with one extra bit so the borrow shows up as the sign.
  always_comb begin
    shifted    = {rem, dvd_bit};
    trial      = {1'b0, shifted} - {2'b00, divisor};
    q_bit_c    = ~trial[PW];
    // Either branch is below the divisor, so it fits back into width bits.
    rem_next_c = q_bit_c ? width'(trial[PW-1:0]) : width'(shifted);
  end

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, accepted in IDLE or DONE
//   a, b       : dividend, divisor (sampled on the accepting edge)
//   busy       : high while dividing
//   done       : one-cycle completion strobe
//   out        : {remainder, quotient}
//   overflow   : divide-by-zero flag for the result on out
module div_seq
  import alu_pkg::*;
#(
  parameter int unsigned width = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [width-1:0]   a,
  input  logic [width-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*width-1:0] out,
  output logic               overflow
);

  localparam int unsigned CW = (width > 1) ? $clog2(width) : 1;
  localparam int unsigned OW = 2 * width;

  div_state_t       state, state_next;
  logic [CW-1:0]    cnt;
  logic [width-1:0] dvd, dvs, rem;
  logic [width-1:0] rem_next;
  logic [width-1:0] dvd_shift;
  logic             q_bit;
  logic             accept, div_zero, last;

  logic             busy_nxt, done_nxt, ovf_nxt;
  logic [OW-1:0]    out_nxt;

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign div_zero  = (b == '0);
  assign last      = (state == RUN) && (cnt == '0);
  // Dividend register doubles as the quotient: quotient bits enter at the LSB.
  assign dvd_shift = width'({dvd, q_bit});

  div_step #(.width(width)) u_step (
    .rem        (rem),
    .dvd_bit    (dvd[width-1]),
    .divisor    (dvs),
    .rem_next_c (rem_next),
    .q_bit_c    (q_bit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_next = div_zero ? DONE : RUN;
        else       state_next = IDLE;
      end
      RUN:     if (cnt == '0) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Output next-values; registered below so nothing reaches a port combinationally.
  always_comb begin
    busy_nxt = (state_next == RUN);
    done_nxt = (state_next == DONE);
    out_nxt  = out;
    ovf_nxt  = overflow;
    if (accept && div_zero) begin
      out_nxt = {a, {width{1'b1}}};
      ovf_nxt = 1'b1;
    end else if (last) begin
      out_nxt = {rem_next, dvd_shift};
      ovf_nxt = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      out      <= '0;
      overflow <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      done     <= done_nxt;
      out      <= out_nxt;
      overflow <= ovf_nxt;
    end
  end

  // Datapath: operand capture, shift/subtract iteration, step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      cnt <= '0;
    end else if (accept) begin
      dvd <= a;
      dvs <= b;
      rem <= '0;
      cnt <= div_zero ? '0 : CW'(width - 1);
    end else if (state == RUN) begin
      dvd <= dvd_shift;
      rem <= rem_next;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq (width = 6).
module tb_div_seq;

  localparam int unsigned W = 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a, b;
  logic           busy, done, overflow;
  logic [2*W-1:0] out;

  int checks   = 0;
  int failures = 0;
  int lat, bcnt;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp_out;
    logic           exp_ovf;
    int             exp_lat;
    int             exp_busy;
  } vec_t;

  vec_t vecs[10];

  div_seq #(.width(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .out      (out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Latency counts the accepting cycle as 1; busy cycles are counted before done.
  task automatic wait_done(output int l, output int bc);
    l  = 1;
    bc = 0;
    while (!done && l < 30) begin
      if (busy) bc++;
      tick();
      l++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int l, output int bc);
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = ~av;
    b     = ~bv;
    wait_done(l, bc);
  endtask

  initial begin
    vecs[0] = '{6'd45, 6'd7,  12'h0C6, 1'b0, 7, 6};
    vecs[1] = '{6'd5,  6'd9,  12'h140, 1'b0, 7, 6};
    vecs[2] = '{6'd63, 6'd1,  12'h03F, 1'b0, 7, 6};
    vecs[3] = '{6'd0,  6'd5,  12'h000, 1'b0, 7, 6};
    vecs[4] = '{6'd17, 6'd0,  12'h47F, 1'b1, 1, 0};
    vecs[5] = '{6'd45, 6'd7,  12'h0C6, 1'b0, 7, 6};
    vecs[6] = '{6'd63, 6'd63, 12'h001, 1'b0, 7, 6};
    vecs[7] = '{6'd62, 6'd63, 12'hF80, 1'b0, 7, 6};
    vecs[8] = '{6'd1,  6'd0,  12'h07F, 1'b1, 1, 0};
    vecs[9] = '{6'd0,  6'd0,  12'h03F, 1'b1, 1, 0};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_out",  32'(out),  32'd0);
    check("reset_ovf",  32'(overflow), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat, bcnt);
      check($sformatf("vec%0d_out", i),  32'(out),      32'(vecs[i].exp_out));
      check($sformatf("vec%0d_ovf", i),  32'(overflow), 32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_lat", i),  32'(lat),      32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_busy", i), 32'(bcnt),     32'(vecs[i].exp_busy));
      tick();
      check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // start re-pulsed mid-RUN is ignored.
    a = 6'd45; b = 6'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 6'd10; b = 6'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, bcnt);
    check("ignore_out", 32'(out), 32'h0C6);
    check("ignore_lat", 32'(lat), 32'd4);
    tick();

    // start held through DONE: second op starts with no IDLE gap.
    a = 6'd50; b = 6'd4; start = 1'b1;
    tick();
    a = 6'd20; b = 6'd3;
    wait_done(lat, bcnt);
    check("b2b_first_out", 32'(out), 32'h08C);
    check("b2b_first_lat", 32'(lat), 32'd7);
    tick();
    check("b2b_no_gap_busy", 32'(busy), 32'd1);
    check("b2b_no_gap_done", 32'(done), 32'd0);
    start = 1'b0;
    a = '0; b = '0;
    wait_done(lat, bcnt);
    check("b2b_second_out", 32'(out), 32'h086);
    check("b2b_second_lat", 32'(lat), 32'd7);
    check("b2b_second_ovf", 32'(overflow), 32'd0);
    tick();

    // Asynchronous reset mid-RUN.
    a = 6'd45; b = 6'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_out",  32'(out),  32'd0);
    check("midrst_ovf",  32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);
    run_op(6'd45, 6'd7, lat, bcnt);
    check("post_rst_out", 32'(out), 32'h0C6);
    check("post_rst_lat", 32'(lat), 32'd7);
    tick();

    // Exhaustive sweep against a reference model.
    for (int ai = 0; ai < 64; ai++) begin
      for (int bi = 0; bi < 64; bi++) begin
        logic [2*W-1:0] exp_o;
        logic           exp_v;
        int             exp_l;
        if (bi == 0) begin
          exp_o = {6'(ai), 6'h3F};
          exp_v = 1'b1;
          exp_l = 1;
        end else begin
          exp_o = {6'(ai % bi), 6'(ai / bi)};
          exp_v = 1'b0;
          exp_l = 7;
        end
        run_op(6'(ai), 6'(bi), lat, bcnt);
        checks++;
        if (out !== exp_o || overflow !== exp_v || lat != exp_l) begin
          failures++;
          $display("FAIL sweep a=%0d b=%0d: got out=%0h ovf=%0b lat=%0d expected out=%0h ovf=%0b lat=%0d",
                   ai, bi, out, overflow, lat, exp_o, exp_v, exp_l);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
